// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared types and defaults for the two-beat 16-bit SRAM controller.
package sram_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;
    localparam int unsigned DEF_BASE_ADDR   = 1024;
    localparam int          DEF_HALF_CYCLES = 2;
    localparam int          DQ_W            = 16;
endpackage

// File: rtl/sram_ctrl_read_buf.sv
// sram_ctrl_read_buf: one-entry last-read tag (valid + word index) with hit compare.
module sram_ctrl_read_buf #(
    parameter int IW = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_i,
    input  logic          clr_i,
    input  logic [IW-1:0] set_idx_i,
    input  logic [IW-1:0] look_idx_i,
    output logic          hit_o
);
    logic          valid_q;
    logic [IW-1:0] idx_q;

    assign hit_o = valid_q && idx_q == look_idx_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end else if (set_i) begin
            valid_q <= 1'b1;
            idx_q   <= set_idx_i;
        end
    end
endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: 32-bit load/store over a 16-bit async SRAM in two half-word accesses.
// Define SRAM_CTRL_READ_BUF_EN to add a one-entry last-read buffer.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          HALF_CYCLES = DEF_HALF_CYCLES,
    parameter int          SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [DQ_W-1:0]    sram_dq_o,
    input  logic [DQ_W-1:0]    sram_dq_i,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);
    localparam int BW = $clog2(HALF_CYCLES);
    localparam int IW = SRAM_AW - 1;
    localparam logic [BW-1:0] LAST = BW'(HALF_CYCLES - 1);

    state_e             state_q, state_d;
    logic [BW-1:0]      beat_q, beat_d;
    logic [IW-1:0]      idx_q, idx_d, req_idx;
    logic               wr_q, wr_d;
    logic [31:0]        wdata_q, wdata_d, off;
    logic [DQ_W-1:0]    lo_q, dq_q, dq_d;
    logic [31:0]        read_data_q;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic               oe_q, oe_d, we_n_q, we_n_d;
    logic               req, hit, last, start, rd_done, active_d, hi_d;
    logic               unused_off;

    assign off        = address - BASE_ADDR;
    assign req_idx    = off[SRAM_AW:2];
    assign unused_off = ^{off[31:SRAM_AW+1], off[1:0]};
    assign req        = rd_en | wr_en;
    assign last       = beat_q == LAST;
    assign start      = state_q == IDLE && req && !hit;
    assign rd_done    = state_q == HIGH && last && !wr_q;
    assign ready      = state_q == IDLE ? (!req || hit) : state_q == DONE;

`ifdef SRAM_CTRL_READ_BUF_EN
    logic buf_hit;

    sram_ctrl_read_buf #(.IW(IW)) u_read_buf (
        .clk        (clk),
        .rst        (rst),
        .set_i      (rd_done),
        .clr_i      (start && wr_en),
        .set_idx_i  (idx_q),
        .look_idx_i (req_idx),
        .hit_o      (buf_hit)
    );

    assign hit = state_q == IDLE && rd_en && !wr_en && buf_hit;
`else
    assign hit = 1'b0;
`endif

    // Pad outputs are registered from next-state values so they line up with the beat they belong to.
    always_comb begin
        idx_d    = start ? req_idx : idx_q;
        wr_d     = start ? wr_en : wr_q;
        wdata_d  = start ? write_data : wdata_q;
        state_d  = state_q == IDLE ? (start ? LOW : IDLE) :
                   state_q == LOW  ? (last ? HIGH : LOW) :
                   state_q == HIGH ? (last ? DONE : HIGH) : IDLE;
        beat_d   = (state_d == state_q && (state_q == LOW || state_q == HIGH)) ? beat_q + 1'b1 : '0;
        active_d = state_d == LOW || state_d == HIGH;
        hi_d     = state_d == HIGH;
        addr_d   = active_d ? {idx_d[IW-1:0], hi_d} : addr_q;
        oe_d     = active_d && wr_d;
        we_n_d   = !(oe_d && beat_d != LAST);
        dq_d     = oe_d ? (hi_d ? wdata_d[31:16] : wdata_d[15:0]) : dq_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            idx_q       <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            lo_q        <= '0;
            read_data_q <= '0;
            addr_q      <= '0;
            dq_q        <= '0;
            oe_q        <= 1'b0;
            we_n_q      <= 1'b1;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            dq_q    <= dq_d;
            oe_q    <= oe_d;
            we_n_q  <= we_n_d;
            if (state_q == LOW && last)
                lo_q <= sram_dq_i;
            if (rd_done)
                read_data_q <= {sram_dq_i, lo_q};
        end
    end

    assign read_data  = read_data_q;
    assign sram_addr  = addr_q;
    assign sram_dq_o  = dq_q;
    assign sram_dq_oe = oe_q;
    assign sram_we_n  = we_n_q;
endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Multi-cycle data-memory controller sitting directly downstream of the MEM stage: takes the MEM stage's memory request (ALU result as address, Rm value as store data, read/write enables) and services it against an external 16-bit asynchronous SRAM. Each 32-bit word takes two half-word accesses. `ready` is low while a request is in flight and drives the pipeline freeze (freeze = ~ready).

## Interface
Parameters:
- `BASE_ADDR`, 1024: CPU byte address mapped to SRAM word 0.
- `HALF_CYCLES`, 2: cycles per half-word access; minimum 2.
- `SRAM_AW`, 18: SRAM half-word address width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `rd_en`  in  1  read request (MEM_R_EN from the MEM stage).
- `wr_en`  in  1  write request (MEM_W_EN); wins if both `rd_en` and `wr_en` are high.
- `address`  in  32  byte address (ALU result); word-aligned.
- `write_data`  in  32  store data (Val_Rm).
- `read_data`  out  32  last word read; registered.
- `ready`  out  1  request complete, or no request pending.
- `sram_addr`  out  SRAM_AW  half-word address.
- `sram_dq_o`  out  16  write data to SRAM.
- `sram_dq_i`  in  16  read data from SRAM.
- `sram_dq_oe`  out  1  pad driver enable.
- `sram_we_n`  out  1  SRAM write strobe, active-low.

## Operation
- Word index = (`address` − `BASE_ADDR`) >> 2. `sram_addr` = {index[SRAM_AW-2:0], h}, where h=0 for the low half and h=1 for the high half.
- States:
  - IDLE: with a request, go to LOW; otherwise stay.
  - LOW: lasts HALF_CYCLES cycles, then HIGH.
  - HIGH: lasts HALF_CYCLES cycles, then DONE.
  - DONE: one cycle, then IDLE unconditionally.
- Beat counter: counts 0..HALF_CYCLES-1 within LOW and HIGH; cleared on every state change.
- `ready` is combinational:
  - IDLE: `ready` = ~(rd_en | wr_en).
  - LOW, HIGH: `ready` = 0.
  - DONE: `ready` = 1.
- Write (LOW/HIGH):
  - `sram_dq_oe`=1.
  - `sram_dq_o` = write_data[15:0] in LOW, write_data[31:16] in HIGH.
  - `sram_we_n`=0 on every beat except the last beat of each half, where it is 1. This gives a rising-edge commit before the address changes.
- Read (LOW/HIGH):
  - `sram_dq_oe`=0, `sram_we_n`=1.
  - `sram_dq_i` is sampled on the last beat of each half into a low or high holding register.
  - `read_data` loads {high, low} on entry to DONE.
- `read_data` holds its value through writes and idle cycles until the next completed read.
- Request inputs are held stable by the frozen pipeline while `ready`=0. A change mid-access is not supported. The latched address/data captured on IDLE→LOW is used for the whole access.
- Reset (any time, including mid-access):
  - state=IDLE, beat=0, `read_data`=0, `sram_addr`=0, `sram_dq_o`=0, `sram_dq_oe`=0, `sram_we_n`=1.
  - Any in-flight access is abandoned.

## Timing
- The request is first seen in IDLE at cycle 0. LOW covers cycles 1..HALF_CYCLES, HIGH the next HALF_CYCLES cycles, and DONE is cycle 2·HALF_CYCLES+1.
- Default: `ready` returns at cycle 5, so each access takes six cycles.
- The pipeline advances on the edge ending DONE. The next instruction's request is seen in IDLE on the following cycle.
- Back-to-back requests: every access includes the IDLE cycle. There is no IDLE bypass.
- Without a request, `ready`=1 continuously with zero latency.

## Configuration
- `SRAM_CTRL_READ_BUF_EN`: one-entry last-read buffer.
- Defined:
  - Stores `buf_valid` and `buf_index`; `buf_valid` resets to 0.
  - Each completed read sets valid and index. Any write clears valid.
  - A read in IDLE with valid and a matching index is a hit: `ready`=1 in the same cycle, `read_data` is unchanged, no SRAM activity, and the state stays IDLE.
- Undefined: no buffer; every read takes the full access.

## Structure
- Package `sram_ctrl_pkg`:
  - state enum (IDLE, LOW, HIGH, DONE);
  - default `BASE_ADDR` and `HALF_CYCLES` constants;
  - SRAM data width (16).
- Sub-module `sram_ctrl_read_buf`: buffer valid/index registers and hit compare. Instantiated only under `SRAM_CTRL_READ_BUF_EN`.

## Test plan
- Reset mid-read:
  - Stimulus: assert `rst`=0 during HIGH.
  - Response: outputs take reset values immediately; after release, `ready`=1 with no request.
- Write, then read back:
  - Stimulus: `wr_en`, `address`=1028, `write_data`=0xDEADBEEF.
  - Response: `sram_addr`=2 then 3; `sram_dq_o`=0xBEEF then 0xDEAD; `ready` high at cycle 5.
  - Then `rd_en`, same address: `read_data`=0xDEADBEEF at cycle 5.
- Simultaneous enables:
  - Stimulus: `rd_en`=`wr_en`=1, `address`=1024, `write_data`=0x12345678.
  - Response: write performed; `read_data` unchanged.
- Back-to-back reads:
  - Stimulus: reads of 1024 and 1032.
  - Response: each sees `ready` low for 5 cycles, high 1 cycle; `sram_addr` sequence 0,1 then 4,5.
- With `SRAM_CTRL_READ_BUF_EN`:
  - Stimulus: read 1040 twice.
  - Response: second read `ready`=1 in cycle 0 with no `sram_addr` change.
  - Then write 1040 and read 1040 again: full 6-cycle access.
- `HALF_CYCLES`=3, write:
  - Response: `sram_we_n` pattern 0,0,1 per half; `ready` at cycle 7.
